wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 27 ++
 rtl/wb_src_fifo.sv | 92 +++++++++
 rtl/wb_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arbiter_pkg
//   Shared definitions for the ROB writeback arbiter:
//     - source indices (ALU, MEM, BR) and the number of sources
//     - per-source FIFO depth (fixed at 2)
//     - src_wrap_inc(): next source index, wrapping BR -> ALU
//   The writeback entry struct {rob_id, value} depends on the top-level width
//   parameters, so it is declared in wb_arbiter and handed to wb_src_fifo as a
//   type parameter.
// -----------------------------------------------------------------------------
package wb_arbiter_pkg;

    typedef logic [1:0] src_idx_t;

    localparam int       NUM_SRC    = 3;
    localparam int       FIFO_DEPTH = 2;

    localparam src_idx_t SRC_ALU = 2'd0;
    localparam src_idx_t SRC_MEM = 2'd1;
    localparam src_idx_t SRC_BR  = 2'd2;

    // Next source in round-robin order: ALU -> MEM -> BR -> ALU.
    function automatic src_idx_t src_wrap_inc(input src_idx_t s);
        return (s == SRC_BR) ? SRC_ALU : s + 2'd1;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// -----------------------------------------------------------------------------
// wb_src_fifo
//   Two-entry FIFO holding writeback entries for one result producer.
//   Slot 0 is always the oldest entry, so dout needs no read pointer.
//   The parent guarantees push only when not full and pop only when not empty;
//   a simultaneous push and pop both take effect and leave count unchanged.
//   flush empties the FIFO and overrides push/pop.
//
// Ports
//   clk_in   in   clock
//   rst_in   in   synchronous active-high reset
//   push     in   write din at the tail
//   pop      in   drop the head entry
//   flush    in   discard all entries
//   din      in   entry to write
//   count    out  number of valid entries (0..2)
//   dout     out  head (oldest) entry
//   empty    out  count == 0
//   full     out  count == 2
// -----------------------------------------------------------------------------
module wb_src_fifo
    import wb_arbiter_pkg::*;
#(
    parameter type entry_t = logic [35:0]
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     din,
    output logic [1:0] count,
    output entry_t     dout,
    output logic       empty,
    output logic       full
);

    entry_t     slot_q [FIFO_DEPTH];
    entry_t     slot_d [FIFO_DEPTH];
    logic [1:0] count_q;
    logic [1:0] count_d;

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    // count_q is 0 or 1 here, so its LSB selects the free slot.
                    slot_d[count_q[0]] = din;
                    count_d            = count_q + 2'd1;
                end
                2'b01: begin
                    slot_d[0] = slot_q[1];
                    count_d   = count_q - 2'd1;
                end
                2'b11: begin
                    // Pop and push together: shift and append, count unchanged.
                    if (count_q == 2'd1) begin
                        slot_d[0] = din;
                    end else begin
                        slot_d[0] = slot_q[1];
                        slot_d[1] = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_q <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign count = count_q;
    assign dout  = slot_q[0];
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
//   Shares the single ROB writeback port between the ALU, memory (LSB) and
//   branch result producers. Each producer pushes into its own 2-entry FIFO;
//   a registered arbiter drains at most one entry per cycle to the ROB.
//
//   Grant policy:
//     default                  round-robin from rr_ptr among non-empty FIFOs
//     WB_ARB_AGE_PRIO_EN set   smallest (rob_id - head_rob_id) mod ROB_SIZE
//                              among FIFO heads; rr_ptr tracked but unused
//
// Ports
//   clk_in, rst_in           clock, synchronous active-high reset
//   rdy_in                   global enable; all state holds when low
//   clear                    ROB mispredict flush (only when rdy_in=1)
//   head_rob_id              ROB head id (age-priority build only)
//   {alu,mem,br}_valid       result offered by the source
//   {alu,mem,br}_rob_id      result tag
//   {alu,mem,br}_value       result data
//   {alu,mem,br}_ready       push accepted (from registered count only)
//   wb_valid                 one-cycle writeback pulse
//   wb_rob_id, wb_value      written-back entry
// -----------------------------------------------------------------------------
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic [ROB_WIDTH-1:0] head_rob_id,
    input  logic                 alu_valid,
    input  logic [ROB_WIDTH-1:0] alu_rob_id,
    input  logic [DATA_W-1:0]    alu_value,
    output logic                 alu_ready,
    input  logic                 mem_valid,
    input  logic [ROB_WIDTH-1:0] mem_rob_id,
    input  logic [DATA_W-1:0]    mem_value,
    output logic                 mem_ready,
    input  logic                 br_valid,
    input  logic [ROB_WIDTH-1:0] br_rob_id,
    input  logic [DATA_W-1:0]    br_value,
    output logic                 br_ready,
    output logic                 wb_valid,
    output logic [ROB_WIDTH-1:0] wb_rob_id,
    output logic [DATA_W-1:0]    wb_value
);

    typedef struct packed {
        logic [ROB_WIDTH-1:0] rob_id;
        logic [DATA_W-1:0]    value;
    } wb_entry_t;

    logic [NUM_SRC-1:0] src_valid;
    logic [NUM_SRC-1:0] src_ready;
    logic [NUM_SRC-1:0] src_push;
    logic [NUM_SRC-1:0] src_pop;
    logic [NUM_SRC-1:0] src_empty;
    logic [NUM_SRC-1:0] src_full_unused;
    logic [1:0]         src_count [NUM_SRC];
    wb_entry_t          src_din   [NUM_SRC];
    wb_entry_t          src_dout  [NUM_SRC];

    logic               grant_valid;
    src_idx_t           grant_idx;

    src_idx_t           rr_q,       rr_d;
    logic               wb_valid_q, wb_valid_d;
    wb_entry_t          wb_entry_q, wb_entry_d;

    logic               fifo_flush;

    assign src_valid         = {br_valid, mem_valid, alu_valid};
    assign src_din[SRC_ALU]  = {alu_rob_id, alu_value};
    assign src_din[SRC_MEM]  = {mem_rob_id, mem_value};
    assign src_din[SRC_BR]   = {br_rob_id,  br_value};

    assign alu_ready = src_ready[SRC_ALU];
    assign mem_ready = src_ready[SRC_MEM];
    assign br_ready  = src_ready[SRC_BR];

    assign fifo_flush = rdy_in && clear;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            // Ready looks only at the registered count; a same-cycle pop
            // does not open a slot early.
            assign src_ready[gi] = rdy_in && (src_count[gi] < 2'd2);
            assign src_push[gi]  = src_valid[gi] && src_ready[gi] && !clear;
            assign src_pop[gi]   = grant_valid && (grant_idx == src_idx_t'(gi));

            wb_src_fifo #(
                .entry_t (wb_entry_t)
            ) u_fifo (
                .clk_in (clk_in),
                .rst_in (rst_in),
                .push   (src_push[gi]),
                .pop    (src_pop[gi]),
                .flush  (fifo_flush),
                .din    (src_din[gi]),
                .count  (src_count[gi]),
                .dout   (src_dout[gi]),
                .empty  (src_empty[gi]),
                .full   (src_full_unused[gi])
            );
        end
    endgenerate

`ifdef WB_ARB_AGE_PRIO_EN
    // Age of each FIFO head relative to the ROB head; natural wrap in
    // ROB_WIDTH bits gives the modulo-ROB_SIZE distance.
    logic [ROB_WIDTH-1:0] src_age [NUM_SRC];

    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_age
            assign src_age[gi] = src_dout[gi].rob_id - head_rob_id;
        end
    endgenerate

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = SRC_ALU;
        if (rdy_in && !clear) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!src_empty[k] &&
                    (!grant_valid || (src_age[k] < src_age[grant_idx]))) begin
                    grant_valid = 1'b1;
                    grant_idx   = src_idx_t'(k);
                end
            end
        end
    end
`else
    logic [ROB_WIDTH-1:0] head_rob_id_unused;
    assign head_rob_id_unused = head_rob_id;

    // Candidate order starting at rr_q; scanning from the last candidate
    // backwards leaves the first non-empty one as the winner.
    src_idx_t cand [NUM_SRC];
    assign cand[0] = rr_q;
    assign cand[1] = src_wrap_inc(rr_q);
    assign cand[2] = src_wrap_inc(cand[1]);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = SRC_ALU;
        if (rdy_in && !clear) begin
            for (int k = NUM_SRC - 1; k >= 0; k--) begin
                if (!src_empty[cand[k]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[k];
                end
            end
        end
    end
`endif

    always_comb begin
        rr_d       = rr_q;
        wb_valid_d = wb_valid_q;
        wb_entry_d = wb_entry_q;
        if (rdy_in) begin
            if (clear) begin
                // Flush: drop the pending pulse, keep last tag/value.
                rr_d       = SRC_ALU;
                wb_valid_d = 1'b0;
            end else if (grant_valid) begin
                rr_d       = src_wrap_inc(grant_idx);
                wb_valid_d = 1'b1;
                wb_entry_d = src_dout[grant_idx];
            end else begin
                wb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_q       <= SRC_ALU;
            wb_valid_q <= 1'b0;
            wb_entry_q <= '0;
        end else begin
            rr_q       <= rr_d;
            wb_valid_q <= wb_valid_d;
            wb_entry_q <= wb_entry_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_rob_id = wb_entry_q.rob_id;
    assign wb_value  = wb_entry_q.value;

endmodule

// File: tb/tb_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_arbiter
//   Self-checking bench for wb_arbiter: a table of directed cycles, a few
//   hand-written multi-cycle sequences and a randomized run, all tracked by a
//   queue-based reference model of the arbiter's rules.
// -----------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [3:0]  head_rob_id;
    logic        alu_valid, mem_valid, br_valid;
    logic [3:0]  alu_rob_id, mem_rob_id, br_rob_id;
    logic [31:0] alu_value, mem_value, br_value;
    logic        alu_ready, mem_ready, br_ready;
    logic        wb_valid;
    logic [3:0]  wb_rob_id;
    logic [31:0] wb_value;

    wb_arbiter #(.ROB_WIDTH(4), .DATA_W(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .head_rob_id (head_rob_id),
        .alu_valid   (alu_valid),
        .alu_rob_id  (alu_rob_id),
        .alu_value   (alu_value),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rob_id  (mem_rob_id),
        .mem_value   (mem_value),
        .mem_ready   (mem_ready),
        .br_valid    (br_valid),
        .br_rob_id   (br_rob_id),
        .br_value    (br_value),
        .br_ready    (br_ready),
        .wb_valid    (wb_valid),
        .wb_rob_id   (wb_rob_id),
        .wb_value    (wb_value)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] val;
    } ent_t;

    ent_t        mq [3][$];
    int          m_rr;
    bit          m_wbv;
    logic [3:0]  m_id;
    logic [31:0] m_val;

    function automatic bit in_v(int s);
        case (s)
            0:       return alu_valid;
            1:       return mem_valid;
            default: return br_valid;
        endcase
    endfunction

    function automatic ent_t in_e(int s);
        ent_t e;
        case (s)
            0:       begin e.id = alu_rob_id; e.val = alu_value; end
            1:       begin e.id = mem_rob_id; e.val = mem_value; end
            default: begin e.id = br_rob_id;  e.val = br_value;  end
        endcase
        return e;
    endfunction

    function automatic void model_flush();
        for (int s = 0; s < 3; s++) mq[s].delete();
        m_rr  = 0;
        m_wbv = 0;
    endfunction

    // One clock edge, evaluated from the inputs held across that edge.
    function automatic void model_edge();
        bit   room [3];
        int   g;
        int   best;
        int   age;
        ent_t e;
        for (int s = 0; s < 3; s++) room[s] = (mq[s].size() < 2);
        if (rst_in) begin
            model_flush();
            m_id  = '0;
            m_val = '0;
        end else if (rdy_in) begin
            if (clear) begin
                model_flush();
            end else begin
                g    = -1;
                best = 0;
`ifdef WB_ARB_AGE_PRIO_EN
                for (int s = 0; s < 3; s++) begin
                    if (mq[s].size() > 0) begin
                        age = (int'(mq[s][0].id) - int'(head_rob_id) + 16) % 16;
                        if (g < 0 || age < best) begin
                            g    = s;
                            best = age;
                        end
                    end
                end
`else
                age = 0;
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && mq[(m_rr + k) % 3].size() > 0) g = (m_rr + k) % 3;
                end
`endif
                if (g >= 0) begin
                    e     = mq[g].pop_front();
                    m_wbv = 1;
                    m_id  = e.id;
                    m_val = e.val;
                    m_rr  = (g + 1) % 3;
                end else begin
                    m_wbv = 0;
                end
                for (int s = 0; s < 3; s++) begin
                    if (in_v(s) && room[s]) mq[s].push_back(in_e(s));
                end
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_src(input int s, input bit v, input logic [3:0] id, input logic [31:0] val);
        case (s)
            0:       begin alu_valid = v; alu_rob_id = id; alu_value = val; end
            1:       begin mem_valid = v; mem_rob_id = id; mem_value = val; end
            default: begin br_valid  = v; br_rob_id  = id; br_value  = val; end
        endcase
    endtask

    task automatic idle();
        for (int s = 0; s < 3; s++) set_src(s, 1'b0, 4'h0, 32'h0);
        clear  = 1'b0;
        rdy_in = 1'b1;
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic do_cycle();
        #1;
        chk("alu_ready", alu_ready, rdy_in && mq[0].size() < 2);
        chk("mem_ready", mem_ready, rdy_in && mq[1].size() < 2);
        chk("br_ready",  br_ready,  rdy_in && mq[2].size() < 2);
        @(posedge clk_in);
        model_edge();
        #1;
        chk("wb_valid",  wb_valid,  m_wbv);
        chk("wb_rob_id", wb_rob_id, m_id);
        chk("wb_value",  wb_value,  m_val);
        $display("cyc t=%0t wb_valid=%0b id=%0d val=%0h", $time, wb_valid, wb_rob_id, wb_value);
        @(negedge clk_in);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [2:0]  v;       // {br, mem, alu}
        logic [11:0] ids;     // {br, mem, alu}
        logic [31:0] aval, mval, bval;
        logic        clr;
        logic [2:0]  exp_ready;  // {br, mem, alu}, during the cycle
        logic        exp_wbv;    // after the edge
        logic [3:0]  exp_id;
        logic [31:0] exp_val;
    } vec_t;

    vec_t tbl [13];

    function automatic vec_t mk(logic [2:0] v, logic [11:0] ids, logic [31:0] a,
                                logic [31:0] m, logic [31:0] b, logic c, logic [2:0] er,
                                logic ev, logic [3:0] eid, logic [31:0] evl);
        vec_t r;
        r.v = v; r.ids = ids; r.aval = a; r.mval = m; r.bval = b; r.clr = c;
        r.exp_ready = er; r.exp_wbv = ev; r.exp_id = eid; r.exp_val = evl;
        return r;
    endfunction

    bit saw_wb;

    initial begin
        // single push, one-cycle pulse
        tbl[0]  = mk(3'b001, 12'h003, 32'h11, 0, 0, 0, 3'b111, 0, 4'd0, 32'h0);
        tbl[1]  = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 1, 4'd3, 32'h11);
        tbl[2]  = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 0, 4'd3, 32'h11);
        // clear to bring rr_ptr back to 0, tag/value hold
        tbl[3]  = mk(3'b000, 12'h000, 0, 0, 0, 1, 3'b111, 0, 4'd3, 32'h11);
        // three-way contention
        tbl[4]  = mk(3'b111, 12'h321, 32'hA, 32'hB, 32'hC, 0, 3'b111, 0, 4'd3, 32'h11);
        tbl[5]  = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 1, 4'd1, 32'hA);
        tbl[6]  = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 1, 4'd2, 32'hB);
        tbl[7]  = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 1, 4'd3, 32'hC);
        tbl[8]  = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 0, 4'd3, 32'hC);
        // rr_ptr back at 0: mem wins over br
        tbl[9]  = mk(3'b110, 12'h650, 0, 32'h55, 32'h66, 0, 3'b111, 0, 4'd3, 32'hC);
        tbl[10] = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 1, 4'd5, 32'h55);
        tbl[11] = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 1, 4'd6, 32'h66);
        tbl[12] = mk(3'b000, 12'h000, 0, 0, 0, 0, 3'b111, 0, 4'd6, 32'h66);

        head_rob_id = 4'd0;
        idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        model_flush();
        m_id  = '0;
        m_val = '0;
        #1;
        chk("rst_wb_valid",  wb_valid,  1'b0);
        chk("rst_wb_rob_id", wb_rob_id, 4'd0);
        chk("rst_wb_value",  wb_value,  32'd0);
        chk("rst_ready", {br_ready, mem_ready, alu_ready}, 3'b111);
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_src(0, tbl[i].v[0], tbl[i].ids[3:0],  tbl[i].aval);
            set_src(1, tbl[i].v[1], tbl[i].ids[7:4],  tbl[i].mval);
            set_src(2, tbl[i].v[2], tbl[i].ids[11:8], tbl[i].bval);
            clear = tbl[i].clr;
            #1;
            chk($sformatf("tbl%0d_ready", i), {br_ready, mem_ready, alu_ready}, tbl[i].exp_ready);
            @(posedge clk_in);
            model_edge();
            #1;
            chk($sformatf("tbl%0d_wb_valid", i), wb_valid,  tbl[i].exp_wbv);
            chk($sformatf("tbl%0d_wb_rob_id", i), wb_rob_id, tbl[i].exp_id);
            chk($sformatf("tbl%0d_wb_value", i), wb_value,  tbl[i].exp_val);
            $display("tbl%0d wb_valid=%0b id=%0d val=%0h", i, wb_valid, wb_rob_id, wb_value);
            @(negedge clk_in);
        end
        idle();

        // full / backpressure on mem while alu holds entries
        set_src(0, 1, 4'd7, 32'h70); set_src(1, 1, 4'd4, 32'h40);
        do_cycle();
        set_src(0, 1, 4'd8, 32'h80); set_src(1, 1, 4'd5, 32'h50);
        do_cycle();
        set_src(0, 0, 4'd0, 32'h0);  set_src(1, 1, 4'd9, 32'h90);
        #1;
        chk("bp_mem_ready_full", mem_ready, 1'b0);
        do_cycle();
        set_src(1, 0, 4'd0, 32'h0);
        chk("bp_wb_mem_first", wb_rob_id, 4'd4);
        repeat (4) do_cycle();

        // flush with a same-cycle push
        idle();
        set_src(0, 1, 4'd1, 32'h1); set_src(1, 1, 4'd2, 32'h2);
        do_cycle();
        clear = 1'b1;
        set_src(0, 1, 4'd3, 32'h3); set_src(1, 0, 4'd0, 32'h0);
        do_cycle();
        chk("flush_wb_valid", wb_valid, 1'b0);
        idle();
        #1;
        chk("flush_ready", {br_ready, mem_ready, alu_ready}, 3'b111);
        saw_wb = 0;
        for (int i = 0; i < 4; i++) begin
            do_cycle();
            if (wb_valid) saw_wb = 1;
        end
        chk("flush_no_wb", saw_wb, 1'b0);

        // stall with entries pending
        set_src(0, 1, 4'd10, 32'hA0); set_src(1, 1, 4'd11, 32'hB0); set_src(2, 1, 4'd12, 32'hC0);
        do_cycle();
        idle();
        do_cycle();
        rdy_in = 1'b0;
        set_src(0, 1, 4'd13, 32'hD0); set_src(1, 1, 4'd14, 32'hE0); set_src(2, 1, 4'd15, 32'hF0);
        repeat (3) do_cycle();
        chk("stall_wb_frozen_id", wb_rob_id, 4'd10);
        chk("stall_wb_frozen_valid", wb_valid, 1'b1);
        idle();
        repeat (3) do_cycle();

`ifdef WB_ARB_AGE_PRIO_EN
        head_rob_id = 4'd14;
        set_src(0, 1, 4'd2, 32'h22); set_src(2, 1, 4'd15, 32'hFF);
        do_cycle();
        idle();
        do_cycle();
        chk("age_first_br", wb_rob_id, 4'd15);
        do_cycle();
        chk("age_second_alu", wb_rob_id, 4'd2);
        do_cycle();
`endif

        // randomized run against the model
        for (int n = 0; n < 600; n++) begin
            for (int s = 0; s < 3; s++)
                set_src(s, ($urandom_range(0, 99) < 55), 4'($urandom), $urandom);
            rdy_in      = ($urandom_range(0, 99) < 88);
            clear       = ($urandom_range(0, 99) < 4);
            rst_in      = ($urandom_range(0, 199) == 0);
            head_rob_id = 4'($urandom);
            do_cycle();
        end
        rst_in = 1'b0;
        idle();
        repeat (4) do_cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
